data_pipe_upsizer: RTL and testbench

Downstream stage of the 8:1 data pipe interconnect. Consumes its `m00` stream of DSIZE-bit beats and packs RATIO consecutive beats into one DSIZE*RATIO-bit word for the wide VDMA write path. It uses the same valid/ready plus `clk_en` handshake rules as the interconnect. A flush request emits a partially filled word at line or frame ends.

---
 rtl/data_pipe_upsizer_if.sv | 21 ++
 rtl/data_pipe_upsizer.sv | 116 +++++++++++
 tb/tb_data_pipe_upsizer.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_pipe_upsizer_if.sv
// Valid/ready beat stream between pipe stages.
// master drives valid/data, slaver drives ready.
interface data_inf #(
  parameter int DSIZE = 8
) ();
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slaver (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/data_pipe_upsizer.sv
// Packs RATIO narrow beats into one wide word, with flush of partial words.
// Ports: clock, rst_n, clk_en, flush, s_in (beats), m_out (words), m_lanes, busy.
module data_pipe_upsizer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       flush,
  data_inf.slaver    s_in,
  data_inf.master    m_out,
  output logic [3:0] m_lanes,
  output logic       busy
);

  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int AW = DSIZE * (RATIO - 1);
  localparam int OW = DSIZE * RATIO;

  logic [CW-1:0] cnt, cnt_n, cnt_pk;
  logic [AW-1:0] acc, acc_n, acc_pk;
  logic [OW-1:0] data_q, data_n;
  logic [3:0]    lanes_q, lanes_n;
  logic          valid_q, valid_n;
  logic          fp, fp_n;

  logic last, slot_open, slot_free;
  logic in_acc, out_acc, flush_now;
  logic full, part, emit, defer;

  assign last      = cnt == CW'(RATIO - 1);
  // Handshake-level view of the slot; clk_en is folded in by in_acc.
  assign slot_open = !valid_q | m_out.ready;
  assign s_in.ready = !fp & !(last & !slot_open);

  assign in_acc    = s_in.valid & s_in.ready & clk_en;
  assign out_acc   = valid_q & m_out.ready & clk_en;
  assign slot_free = !valid_q | out_acc;
  assign flush_now = clk_en & (flush | fp);

  assign m_out.valid = valid_q;
  assign m_out.data  = data_q;
  assign m_lanes     = lanes_q;
  assign busy        = (cnt != '0) | valid_q | fp;

  // Accumulator/count after packing a non-completing beat.
  always_comb begin
    acc_pk = acc;
    cnt_pk = cnt;
    if (in_acc && !last) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (cnt == CW'(i)) begin
          acc_pk[i*DSIZE +: DSIZE] = s_in.data;
        end
      end
      cnt_pk = cnt + 1'b1;
    end
  end

  assign full  = in_acc & last;
  assign part  = flush_now & !full & (cnt_pk != '0);
  assign emit  = part & slot_free;
  assign defer = part & !slot_free;

  always_comb begin
    cnt_n   = cnt_pk;
    acc_n   = acc_pk;
    data_n  = data_q;
    lanes_n = lanes_q;
    valid_n = valid_q & !out_acc;
    fp_n    = fp;
    unique case (1'b1)
      full: begin
        data_n  = {s_in.data, acc};
        lanes_n = 4'(RATIO);
        valid_n = 1'b1;
        cnt_n   = '0;
        acc_n   = '0;
        fp_n    = 1'b0;
      end
      emit: begin
        data_n  = OW'(acc_pk);
        lanes_n = 4'(cnt_pk);
        valid_n = 1'b1;
        cnt_n   = '0;
        acc_n   = '0;
        fp_n    = 1'b0;
      end
      defer: begin
        fp_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      data_q  <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
      fp      <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      acc     <= acc_n;
      data_q  <= data_n;
      lanes_q <= lanes_n;
      valid_q <= valid_n;
      fp      <= fp_n;
    end
  end

endmodule

// File: tb/tb_data_pipe_upsizer.sv
// Directed bench for data_pipe_upsizer (DSIZE=8, RATIO=4).
// Output words are captured by a monitor and checked per scenario.
module tb_data_pipe_upsizer;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] m_lanes;
  logic       busy;

  data_inf #(.DSIZE(8))  s_if ();
  data_inf #(.DSIZE(32)) m_if ();

  data_pipe_upsizer #(.DSIZE(8), .RATIO(4)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .flush   (flush),
    .s_in    (s_if),
    .m_out   (m_if),
    .m_lanes (m_lanes),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_lanes[$];
  int          q_cyc[$];

  // Inputs change only at posedge+1, so a negedge sample predicts the accept.
  always @(negedge clock) begin
    cyc++;
    if (rst_n && clk_en && m_if.valid && m_if.ready) begin
      q_data.push_back(m_if.data);
      q_lanes.push_back(m_lanes);
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d);
    s_if.valid = 1'b1;
    s_if.data  = d;
    tick(1);
    s_if.valid = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_lanes.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (m_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", m_if.valid);
    end
    n_checks++;
    if (m_if.data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", m_if.data);
    end
    n_checks++;
    if (m_lanes !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_lanes got %0d want 0", m_lanes);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (s_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", s_if.ready);
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    tick(1);
    clear_q();
  endtask

  task automatic test_full_throughput();
    int stalls;
    stalls = 0;
    m_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(i);
      #1;
      if (s_if.ready !== 1'b1) stalls++;
      tick(1);
    end
    s_if.valid = 1'b0;
    tick(3);
    n_checks++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL tput_ready stalls=%0d want 0", stalls);
    end
    n_checks++;
    if (q_data.size() != 2) begin
      n_fail++;
      $display("FAIL tput_count got %0d want 2", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 32'h04030201 || q_lanes[0] !== 4'd4) begin
        n_fail++;
        $display("FAIL tput_w0 got %h/%0d want 04030201/4",
                 q_data[0], q_lanes[0]);
      end
      n_checks++;
      if (q_data[1] !== 32'h08070605 || q_lanes[1] !== 4'd4) begin
        n_fail++;
        $display("FAIL tput_w1 got %h/%0d want 08070605/4",
                 q_data[1], q_lanes[1]);
      end
      n_checks++;
      if (q_cyc[1] - q_cyc[0] != 4) begin
        n_fail++;
        $display("FAIL tput_gap got %0d want 4", q_cyc[1] - q_cyc[0]);
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    int early_stall;
    early_stall = 0;
    m_if.ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(i);
      #1;
      if (s_if.ready !== 1'b1) early_stall++;
      tick(1);
    end
    s_if.data = 8'h08;
    #1;
    n_checks++;
    if (early_stall != 0) begin
      n_fail++;
      $display("FAIL bp_early_ready stalls=%0d want 0", early_stall);
    end
    tick(2);
    n_checks++;
    if (s_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall_ready got %b want 0", s_if.ready);
    end
    m_if.ready = 1'b1;
    #1;
    n_checks++;
    if (s_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_comb_ready got %b want 1", s_if.ready);
    end
    tick(1);
    s_if.valid = 1'b0;
    tick(3);
    n_checks++;
    if (q_data.size() != 2) begin
      n_fail++;
      $display("FAIL bp_count got %0d want 2", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 32'h04030201 || q_data[1] !== 32'h08070605) begin
        n_fail++;
        $display("FAIL bp_words got %h,%h want 04030201,08070605",
                 q_data[0], q_data[1]);
      end
    end
    clear_q();
  endtask

  task automatic test_flush_partial();
    m_if.ready = 1'b0;
    beat(8'hAA);
    beat(8'hBB);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    n_checks++;
    if (m_if.valid !== 1'b1 || m_if.data !== 32'h0000BBAA ||
        m_lanes !== 4'd2) begin
      n_fail++;
      $display("FAIL flush_word got %b/%h/%0d want 1/0000bbaa/2",
               m_if.valid, m_if.data, m_lanes);
    end
    m_if.ready = 1'b1;
    tick(2);
    n_checks++;
    if (busy !== 1'b0 || q_data.size() != 1) begin
      n_fail++;
      $display("FAIL flush_drain busy=%b n=%0d want 0/1",
               busy, q_data.size());
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(2);
    n_checks++;
    if (q_data.size() != 1 || m_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty n=%0d valid=%b want 1/0",
               q_data.size(), m_if.valid);
    end
    clear_q();
  endtask

  task automatic test_flush_pending();
    m_if.ready = 1'b0;
    beat(8'h21);
    beat(8'h22);
    beat(8'h23);
    beat(8'h24);
    beat(8'h11);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(2);
    n_checks++;
    if (s_if.ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_hold ready=%b busy=%b want 0/1",
               s_if.ready, busy);
    end
    m_if.ready = 1'b1;
    tick(4);
    n_checks++;
    if (q_data.size() != 2) begin
      n_fail++;
      $display("FAIL pend_count got %0d want 2", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 32'h24232221 || q_lanes[0] !== 4'd4) begin
        n_fail++;
        $display("FAIL pend_w0 got %h/%0d want 24232221/4",
                 q_data[0], q_lanes[0]);
      end
      n_checks++;
      if (q_data[1] !== 32'h00000011 || q_lanes[1] !== 4'd1) begin
        n_fail++;
        $display("FAIL pend_w1 got %h/%0d want 00000011/1",
                 q_data[1], q_lanes[1]);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || s_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_clear busy=%b ready=%b want 0/1",
               busy, s_if.ready);
    end
    clear_q();
  endtask

  task automatic test_clk_en();
    m_if.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      clk_en     = (i % 2 == 0);
      s_if.valid = 1'b1;
      s_if.data  = 8'(8'h40 + i);
      tick(1);
    end
    s_if.valid = 1'b0;
    clk_en = 1'b1;
    tick(3);
    n_checks++;
    if (q_data.size() != 2) begin
      n_fail++;
      $display("FAIL clken_count got %0d want 2", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 32'h46444240 || q_data[1] !== 32'h4E4C4A48) begin
        n_fail++;
        $display("FAIL clken_words got %h,%h want 46444240,4e4c4a48",
                 q_data[0], q_data[1]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_idle busy=%b want 0", busy);
    end
    clear_q();
  endtask

  task automatic test_reset_mid_word();
    m_if.ready = 1'b0;
    beat(8'h61);
    beat(8'h62);
    beat(8'h63);
    beat(8'h64);
    beat(8'h51);
    beat(8'h52);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_if.valid !== 1'b0 || m_if.data !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear valid=%b data=%h busy=%b want 0/0/0",
               m_if.valid, m_if.data, busy);
    end
    tick(1);
    rst_n = 1'b1;
    m_if.ready = 1'b1;
    clear_q();
    tick(1);
    beat(8'h71);
    beat(8'h72);
    beat(8'h73);
    beat(8'h74);
    tick(3);
    n_checks++;
    if (q_data.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_count got %0d want 1", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 32'h74737271 || q_lanes[0] !== 4'd4) begin
        n_fail++;
        $display("FAIL rstmid_word got %h/%0d want 74737271/4",
                 q_data[0], q_lanes[0]);
      end
    end
    clear_q();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_throughput();
    test_backpressure();
    test_flush_partial();
    test_flush_pending();
    test_clk_en();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
